// File: rtl/nx_stream_arbiter_pkg.sv
// Shared types and constants for nx_stream_arbiter.
package nx_stream_arb_pkg;

    localparam int ARB_BUF_DEPTH = 2;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_LOCK_CTRL,
        ARB_LOCK_MESH
    } arb_state_t;

    typedef enum logic {
        SRC_CTRL = 1'b0,
        SRC_MESH = 1'b1
    } arb_src_t;

endpackage

// File: rtl/nx_stream_arbiter_if.sv
// AXI4-stream bundle used for both merged inputs and the host output.
// Handshake: a beat moves on a rising clk edge where tvalid and tready are
// both high; the master holds tdata/tlast/tuser stable while tvalid & !tready.
interface nx_stream_arbiter_if #(
    parameter int W = 128
) ();
    logic [W-1:0] tdata;
    logic         tlast;
    logic         tuser;
    logic         tvalid;
    logic         tready;

    modport master (output tdata, output tlast, output tuser, output tvalid, input tready);
    modport slave  (input tdata, input tlast, input tuser, input tvalid, output tready);
endinterface

// File: rtl/nx_stream_arbiter_skid.sv
// nx_stream_skid: 2-entry FIFO of {tuser, tlast, tdata}. Output comes straight
// from storage registers, and space depends only on the registered count, so
// the downstream ready never reaches the upstream ready combinationally.
module nx_stream_skid
    import nx_stream_arb_pkg::*;
#(
    parameter int W = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W+1:0] push_data,
    output logic         space,
    output logic         out_valid,
    output logic [W+1:0] out_data,
    input  logic         out_ready
);

    logic [W+1:0] mem [ARB_BUF_DEPTH];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   count;
    logic         do_push;
    logic         do_pop;

    assign space     = (count < 2'(ARB_BUF_DEPTH));
    assign out_valid = (count != 2'd0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign do_push   = push & space;
    assign do_pop    = out_valid & out_ready;

    // Storage, pointers and occupancy; push and pop in one cycle leave count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < ARB_BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/nx_stream_arbiter.sv
// nx_stream_arbiter: packet-atomic round-robin merge of the ctrl and mesh
// streams onto the host stream, tagging each beat's source on host.tuser
// (0 = ctrl, 1 = mesh). Optional packet counters: NX_STREAM_ARB_STATS_EN.
module nx_stream_arbiter
    import nx_stream_arb_pkg::*;
#(
    parameter int AXI4_DATA_WIDTH = 128
) (
    input  logic        clk,
    input  logic        rst,
    nx_stream_arbiter_if.slave  ctrl,
    nx_stream_arbiter_if.slave  mesh,
    nx_stream_arbiter_if.master host,
    output logic        status_busy,
    output arb_state_t  dbg_state
`ifdef NX_STREAM_ARB_STATS_EN
    ,
    output logic [31:0] ctrl_pkt_count,
    output logic [31:0] mesh_pkt_count
`endif
);

    localparam int W = AXI4_DATA_WIDTH;

    arb_state_t   state;
    arb_src_t     last_grant;
    logic         space;
    logic         space_ok;
    logic         ctrl_rdy;
    logic         mesh_rdy;
    logic         ctrl_fire;
    logic         mesh_fire;
    logic         push;
    logic [W+1:0] push_data;
    logic [W+1:0] host_beat;
    logic         buf_valid;

    // Nothing is accepted while reset is asserted.
    assign space_ok = space & ~rst;

    // Grant: a locked source owns the input; otherwise sole requester wins,
    // and on a tie the source that was not granted last wins.
    always_comb begin
        ctrl_rdy = 1'b0;
        mesh_rdy = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (ctrl.tvalid && (!mesh.tvalid || last_grant == SRC_MESH)) begin
                    ctrl_rdy = space_ok;
                end else if (mesh.tvalid) begin
                    mesh_rdy = space_ok;
                end
            end
            ARB_LOCK_CTRL: ctrl_rdy = space_ok;
            ARB_LOCK_MESH: mesh_rdy = space_ok;
            default: ;
        endcase
    end

    assign ctrl.tready = ctrl_rdy;
    assign mesh.tready = mesh_rdy;
    assign ctrl_fire   = ctrl.tvalid & ctrl_rdy;
    assign mesh_fire   = mesh.tvalid & mesh_rdy;
    assign push        = ctrl_fire | mesh_fire;
    assign push_data   = ctrl_fire ? {1'(SRC_CTRL), ctrl.tlast, ctrl.tdata}
                                   : {1'(SRC_MESH), mesh.tlast, mesh.tdata};

    nx_stream_skid #(.W(W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .space     (space),
        .out_valid (buf_valid),
        .out_data  (host_beat),
        .out_ready (host.tready)
    );

    assign host.tvalid = buf_valid;
    assign host.tuser  = host_beat[W+1];
    assign host.tlast  = host_beat[W];
    assign host.tdata  = host_beat[W-1:0];
    assign status_busy = (state != ARB_IDLE) | buf_valid;
    assign dbg_state   = state;

    // Packet lock FSM: a non-last beat locks its source until its tlast is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ARB_IDLE;
            last_grant <= SRC_MESH;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (ctrl_fire) begin
                        if (ctrl.tlast) last_grant <= SRC_CTRL;
                        else            state      <= ARB_LOCK_CTRL;
                    end else if (mesh_fire) begin
                        if (mesh.tlast) last_grant <= SRC_MESH;
                        else            state      <= ARB_LOCK_MESH;
                    end
                end
                ARB_LOCK_CTRL: begin
                    if (ctrl_fire && ctrl.tlast) begin
                        last_grant <= SRC_CTRL;
                        state      <= ARB_IDLE;
                    end
                end
                ARB_LOCK_MESH: begin
                    if (mesh_fire && mesh.tlast) begin
                        last_grant <= SRC_MESH;
                        state      <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

`ifdef NX_STREAM_ARB_STATS_EN
    logic [31:0] ctrl_cnt_q;
    logic [31:0] mesh_cnt_q;

    // Completed-packet counters, bumped when a tlast beat enters the buffer; wrap freely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_cnt_q <= 32'd0;
            mesh_cnt_q <= 32'd0;
        end else begin
            if (ctrl_fire && ctrl.tlast) ctrl_cnt_q <= ctrl_cnt_q + 32'd1;
            if (mesh_fire && mesh.tlast) mesh_cnt_q <= mesh_cnt_q + 32'd1;
        end
    end

    assign ctrl_pkt_count = ctrl_cnt_q;
    assign mesh_pkt_count = mesh_cnt_q;
`endif

endmodule

// File: tb/tb_nx_stream_arbiter.sv
// Bench for nx_stream_arbiter: hand-derived vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
// Packet counter checks are built when NX_STREAM_ARB_STATS_EN is defined.
module tb_nx_stream_arbiter;
    import nx_stream_arb_pkg::*;

    localparam int W  = 128;
    localparam int BW = W + 2;

    logic clk;
    logic rst;
    logic status_busy;
    arb_state_t dbg_state;
`ifdef NX_STREAM_ARB_STATS_EN
    logic [31:0] ctrl_pkt_count;
    logic [31:0] mesh_pkt_count;
`endif

    nx_stream_arbiter_if #(.W(W)) ctrl_if ();
    nx_stream_arbiter_if #(.W(W)) mesh_if ();
    nx_stream_arbiter_if #(.W(W)) host_if ();

    nx_stream_arbiter #(.AXI4_DATA_WIDTH(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .ctrl           (ctrl_if.slave),
        .mesh           (mesh_if.slave),
        .host           (host_if.master),
        .status_busy    (status_busy),
        .dbg_state      (dbg_state)
`ifdef NX_STREAM_ARB_STATS_EN
        ,
        .ctrl_pkt_count (ctrl_pkt_count),
        .mesh_pkt_count (mesh_pkt_count)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: buffer contents are the expected queue itself.
    logic [BW-1:0] exp_q[$];
    int            m_owner;   // -1 none, 0 ctrl locked, 1 mesh locked
    int            m_last;    // source granted last: 0 ctrl, 1 mesh
    int            cnt_c, cnt_m;

    // Source packet generators.
    logic [31:0] c_seq, m_seq;
    int          c_idx, m_idx, c_len, m_len;
    int          c_fix, m_fix;
    int          c_lens[$];
    int          m_lens[$];

    // Observations from the most recent step.
    logic s_crdy, s_mrdy, s_hv, s_hu;
    logic       pop_u[$];
    logic [31:0] pop_d[$];

    typedef struct {
        bit cv, mv, hr;
        bit ec, em, ehv, ehu;
    } vec_t;
    vec_t vecs[10];

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int next_c_len();
        if (c_lens.size() > 0) return c_lens.pop_front();
        if (c_fix != 0) return c_fix;
        return int'($urandom_range(1, 4));
    endfunction

    function automatic int next_m_len();
        if (m_lens.size() > 0) return m_lens.pop_front();
        if (m_fix != 0) return m_fix;
        return int'($urandom_range(1, 4));
    endfunction

    task automatic reset_gen();
        c_idx = 0;
        m_idx = 0;
        c_len = next_c_len();
        m_len = next_m_len();
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_owner = -1;
        m_last  = 1;
        cnt_c   = 0;
        cnt_m   = 0;
    endtask

    function automatic logic [BW-1:0] c_beat();
        return {1'b0, 1'(c_idx == c_len - 1), 96'd0, c_seq};
    endfunction

    function automatic logic [BW-1:0] m_beat();
        return {1'b1, 1'(m_idx == m_len - 1), 96'd0, m_seq};
    endfunction

    task automatic drive(input bit cv, input bit mv, input bit hr);
        logic [BW-1:0] cb, mb;
        cb = c_beat();
        mb = m_beat();
        ctrl_if.tvalid = cv;
        ctrl_if.tdata  = cb[W-1:0];
        ctrl_if.tlast  = cb[W];
        ctrl_if.tuser  = 1'b0;
        mesh_if.tvalid = mv;
        mesh_if.tdata  = mb[W-1:0];
        mesh_if.tlast  = mb[W];
        mesh_if.tuser  = 1'b0;
        host_if.tready = hr;
    endtask

    // One clock cycle: drive, check against the model, then advance the model.
    task automatic step(input bit cv, input bit mv, input bit hr);
        logic ec, em, sp, lst;
        int win;
        logic [BW-1:0] cb, mb;
        @(negedge clk);
        drive(cv, mv, hr);
        cb = c_beat();
        mb = m_beat();
        #1;
        sp = (exp_q.size() < 2);
        ec = 1'b0;
        em = 1'b0;
        if (m_owner == 0) ec = sp;
        else if (m_owner == 1) em = sp;
        else begin
            win = -1;
            if (cv && mv) win = 1 - m_last;
            else if (cv) win = 0;
            else if (mv) win = 1;
            if (win == 0) ec = sp;
            if (win == 1) em = sp;
        end
        chk("ctrl_tready", ctrl_if.tready, ec);
        chk("mesh_tready", mesh_if.tready, em);
        chk("host_tvalid", host_if.tvalid, exp_q.size() > 0);
        if (exp_q.size() > 0)
            chk("host_beat", {host_if.tuser, host_if.tlast, host_if.tdata}, exp_q[0]);
        chk("status_busy", status_busy, (m_owner != -1) || (exp_q.size() > 0));
        s_crdy = ctrl_if.tready;
        s_mrdy = mesh_if.tready;
        s_hv   = host_if.tvalid;
        s_hu   = host_if.tuser;
        if (host_if.tvalid && hr) begin
            pop_u.push_back(host_if.tuser);
            pop_d.push_back(host_if.tdata[31:0]);
        end
        // Model advance for the coming rising edge.
        if (exp_q.size() > 0 && hr) void'(exp_q.pop_front());
        if (cv && ec) begin
            exp_q.push_back(cb);
            lst = cb[W];
            c_seq++;
            if (lst) begin
                c_idx = 0; c_len = next_c_len(); m_owner = -1; m_last = 0; cnt_c++;
            end else begin
                c_idx++; m_owner = 0;
            end
        end else if (mv && em) begin
            exp_q.push_back(mb);
            lst = mb[W];
            m_seq++;
            if (lst) begin
                m_idx = 0; m_len = next_m_len(); m_owner = -1; m_last = 1; cnt_m++;
            end else begin
                m_idx++; m_owner = 1;
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && exp_q.size() > 0; i++) step(0, 0, 1);
        step(0, 0, 1);
    endtask

    // Holds reset with both sources requesting; nothing may be accepted.
    task automatic do_reset();
        reset_gen();
        @(negedge clk);
        rst = 1'b1;
        drive(1, 1, 0);
        #1;
        chk("rst_ctrl_tready", ctrl_if.tready, 0);
        chk("rst_mesh_tready", mesh_if.tready, 0);
        chk("rst_host_tvalid", host_if.tvalid, 0);
        chk("rst_status_busy", status_busy, 0);
        repeat (2) @(negedge clk);
        drive(0, 0, 0);
        rst = 1'b0;
        model_reset();
        #1;
        chk("rst_state_idle", dbg_state, ARB_IDLE);
`ifdef NX_STREAM_ARB_STATS_EN
        chk("rst_ctrl_cnt", ctrl_pkt_count, 0);
        chk("rst_mesh_cnt", mesh_pkt_count, 0);
`endif
    endtask

    initial begin
        int bad;
        rst   = 1'b1;
        c_seq = 32'h0000_1000;
        m_seq = 32'h8000_0000;
        c_fix = 1;
        m_fix = 1;
        model_reset();
        drive(0, 0, 0);

        // Table: {cv, mv, hr, exp ctrl_tready, mesh_tready, host_tvalid, host_tuser}
        vecs[0] = '{1, 1, 1, 1, 0, 0, 0};
        vecs[1] = '{1, 1, 1, 0, 1, 1, 0};
        vecs[2] = '{1, 1, 1, 1, 0, 1, 1};
        vecs[3] = '{1, 1, 0, 0, 1, 1, 0};
        vecs[4] = '{1, 0, 0, 0, 0, 1, 0};
        vecs[5] = '{1, 1, 1, 0, 0, 1, 0};
        vecs[6] = '{1, 1, 1, 1, 0, 1, 1};
        vecs[7] = '{0, 1, 1, 1, 0, 1, 0};
        vecs[8] = '{1, 1, 1, 1, 0, 0, 0};
        vecs[9] = '{1, 1, 1, 0, 1, 1, 0};

        // Reset with both valid, then ctrl wins the first contest.
        do_reset();
        step(1, 1, 1);
        chk("first_grant_ctrl", {s_crdy, s_mrdy}, 2'b10);
        step(0, 0, 1);
        chk("first_out_valid", s_hv, 1);
        chk("first_out_tuser", s_hu, 0);
        drain();

        // Vector table: ctrl packets of 1,1,2 beats, single-beat mesh packets.
        c_lens = '{1, 1, 2};
        m_fix  = 1;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(vecs[i].cv, vecs[i].mv, vecs[i].hr);
            chk($sformatf("vec%0d_ctrl_tready", i), s_crdy, vecs[i].ec);
            chk($sformatf("vec%0d_mesh_tready", i), s_mrdy, vecs[i].em);
            chk($sformatf("vec%0d_host_tvalid", i), s_hv, vecs[i].ehv);
            if (vecs[i].ehv) chk($sformatf("vec%0d_host_tuser", i), s_hu, vecs[i].ehu);
        end
        drain();

        // Both sources stream 3-beat packets: ctrl x3, mesh x3, ... at 1 beat/cycle.
        c_fix = 3;
        m_fix = 3;
        do_reset();
        pop_u.delete();
        repeat (14) step(1, 1, 1);
        chk("rr_beats_out", pop_u.size(), 13);
        bad = 0;
        for (int k = 0; k < 12 && k < pop_u.size(); k++)
            if (pop_u[k] != 1'((k / 3) % 2)) bad++;
        chk("rr_pattern_errors", bad, 0);

        // Mesh 4-beat packet holds the lock against a late ctrl request.
        c_fix = 2;
        m_fix = 4;
        do_reset();
        step(0, 1, 1);
        step(1, 1, 1);
        chk("lock_ctrl_blocked_b2", s_crdy, 0);
        step(1, 1, 1);
        chk("lock_ctrl_blocked_b3", s_crdy, 0);
        step(1, 1, 1);
        chk("lock_mesh_last_ready", {s_crdy, s_mrdy}, 2'b01);
        step(1, 1, 1);
        chk("ctrl_after_mesh_last", {s_crdy, s_mrdy}, 2'b10);
        drain();

        // Backpressure: ctrl 0x1..0x8 with host stalled 5 cycles.
        c_fix = 8;
        do_reset();
        c_seq = 32'd1;
        pop_d.delete();
        repeat (5) step(1, 0, 0);
        chk("full_ctrl_tready", s_crdy, 0);
        chk("full_mesh_tready", s_mrdy, 0);
        for (int i = 0; i < 20 && pop_d.size() < 8; i++) step(c_seq <= 32'd8, 0, 1);
        chk("bp_beats_out", pop_d.size(), 8);
        bad = 0;
        for (int k = 0; k < pop_d.size(); k++)
            if (pop_d[k] != 32'(k + 1)) bad++;
        chk("bp_order_errors", bad, 0);
        drain();

        // Reset pulse after 2 of 4 mesh beats drops everything.
        m_fix = 4;
        c_fix = 1;
        do_reset();
        step(0, 1, 0);
        step(0, 1, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("pulse_ctrl_tready", ctrl_if.tready, 0);
        chk("pulse_mesh_tready", mesh_if.tready, 0);
        @(negedge clk);
        drive(0, 0, 0);
        rst = 1'b0;
        model_reset();
        reset_gen();
        #1;
        chk("pulse_host_tvalid", host_if.tvalid, 0);
        chk("pulse_status_busy", status_busy, 0);
        step(1, 1, 1);
        chk("pulse_grant_ctrl", {s_crdy, s_mrdy}, 2'b10);
        drain();

        // Randomized traffic against the model.
        c_fix = 0;
        m_fix = 0;
        do_reset();
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        drain();
`ifdef NX_STREAM_ARB_STATS_EN
        chk("rand_ctrl_cnt", ctrl_pkt_count, 32'(cnt_c));
        chk("rand_mesh_cnt", mesh_pkt_count, 32'(cnt_m));

        // 10 single-beat ctrl + 7 three-beat mesh packets.
        c_fix = 1;
        m_fix = 3;
        do_reset();
        for (int i = 0; i < 300 && (cnt_c < 10 || cnt_m < 7); i++)
            step(cnt_c < 10, cnt_m < 7, 1);
        drain();
        chk("stats_ctrl_cnt", ctrl_pkt_count, 32'd10);
        chk("stats_mesh_cnt", mesh_pkt_count, 32'd7);

        // Wrap: preload all-ones, one more ctrl packet reads back 0.
        @(negedge clk);
        force dut.ctrl_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.ctrl_cnt_q;
        step(1, 0, 1);
        step(0, 0, 1);
        chk("stats_ctrl_wrap", ctrl_pkt_count, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
